// File: rtl/gate_and_nand_xor_unit.sv
// gate_and_nand_xor_unit: registered bitwise AND/NAND/XOR of a,b (clk, rst, in_valid, a, b -> and_out, nand_out, xor_out, out_valid)
module gate_and_nand_xor_unit #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] and_out,
  output logic [WIDTH-1:0] nand_out,
  output logic [WIDTH-1:0] xor_out,
  output logic             out_valid
);
  logic [WIDTH-1:0] and_q, and_d, nand_q, nand_d, xor_q, xor_d;
  logic             valid_q, valid_d;
  always_comb begin
    and_d   = in_valid ? a & b    : and_q;
    nand_d  = in_valid ? ~(a & b) : nand_q;
    xor_d   = in_valid ? a ^ b    : xor_q;
    valid_d = in_valid;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      and_q   <= '0;
      nand_q  <= '1;
      xor_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      and_q   <= and_d;
      nand_q  <= nand_d;
      xor_q   <= xor_d;
      valid_q <= valid_d;
    end
  end
  assign and_out   = and_q;
  assign nand_out  = nand_q;
  assign xor_out   = xor_q;
  assign out_valid = valid_q;
endmodule

// File: tb/tb_gate_and_nand_xor_unit.sv
// tb_gate_and_nand_xor_unit: directed and randomized checks of the scalar and 8-bit gate unit
module tb_gate_and_nand_xor_unit;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       v1 = 1'b0, v8 = 1'b0;
  logic       a1 = 1'b0, b1 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       and1, nand1, xor1, ov1;
  logic [7:0] and8, nand8, xor8;
  logic       ov8;
  int         vectors = 0;
  int         miscompares = 0;
  always #5 clk = ~clk;
  gate_and_nand_xor_unit #(.WIDTH(1)) u1 (
    .clk(clk), .rst(rst), .in_valid(v1), .a(a1), .b(b1),
    .and_out(and1), .nand_out(nand1), .xor_out(xor1), .out_valid(ov1)
  );
  gate_and_nand_xor_unit #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(v8), .a(a8), .b(b8),
    .and_out(and8), .nand_out(nand8), .xor_out(xor8), .out_valid(ov8)
  );
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    rst = 1'b1; v1 = 1'b1; a1 = 1'b1; b1 = 1'b1;
    v8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF;
    for (int i = 0; i < 2; i++) begin
      cyc();
      vectors++;
      if ({and1, nand1, xor1, ov1} !== 4'b0100) begin
        miscompares++;
        $display("FAIL reset_w1 cyc%0d got and/nand/xor/v=%b%b%b%b want 0100", i, and1, nand1, xor1, ov1);
      end
      vectors++;
      if ({and8, nand8, xor8, ov8} !== {8'h00, 8'hFF, 8'h00, 1'b0}) begin
        miscompares++;
        $display("FAIL reset_w8 cyc%0d got %h %h %h %b want 00 ff 00 0", i, and8, nand8, xor8, ov8);
      end
    end
    rst = 1'b0; v1 = 1'b0; v8 = 1'b0;
  endtask
  task automatic test_truth_table();
    logic [1:0] ab [4];
    logic [2:0] exp [4];
    ab  = '{2'b00, 2'b10, 2'b01, 2'b11};
    exp = '{3'b010, 3'b011, 3'b011, 3'b100};
    for (int i = 0; i < 4; i++) begin
      {a1, b1} = ab[i]; v1 = 1'b1;
      cyc();
      vectors++;
      if ({and1, nand1, xor1, ov1} !== {exp[i], 1'b1}) begin
        miscompares++;
        $display("FAIL truth a=%b b=%b got and/nand/xor/v=%b%b%b%b want %b1", ab[i][1], ab[i][0], and1, nand1, xor1, ov1, exp[i]);
      end
    end
    v1 = 1'b0;
  endtask
  task automatic test_hold();
    a1 = 1'b1; b1 = 1'b1; v1 = 1'b1;
    cyc();
    vectors++;
    if ({and1, nand1, xor1, ov1} !== 4'b1001) begin
      miscompares++;
      $display("FAIL hold_load got %b%b%b%b want 1001", and1, nand1, xor1, ov1);
    end
    v1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      a1 = 1'($urandom); b1 = 1'($urandom);
      cyc();
      vectors++;
      if ({and1, nand1, xor1, ov1} !== 4'b1000) begin
        miscompares++;
        $display("FAIL hold cyc%0d got %b%b%b%b want 1000", i, and1, nand1, xor1, ov1);
      end
    end
  endtask
  task automatic test_vector();
    a8 = 8'hF0; b8 = 8'hAA; v8 = 1'b1;
    cyc();
    vectors++;
    if ({and8, nand8, xor8, ov8} !== {8'hA0, 8'h5F, 8'h5A, 1'b1}) begin
      miscompares++;
      $display("FAIL vec_f0_aa got %h %h %h %b want a0 5f 5a 1", and8, nand8, xor8, ov8);
    end
    a8 = 8'hFF; b8 = 8'hFF;
    cyc();
    vectors++;
    if ({and8, nand8, xor8, ov8} !== {8'hFF, 8'h00, 8'h00, 1'b1}) begin
      miscompares++;
      $display("FAIL vec_ff_ff got %h %h %h %b want ff 00 00 1", and8, nand8, xor8, ov8);
    end
    v8 = 1'b0;
  endtask
  task automatic test_reset_priority();
    logic [7:0] ea, eb;
    v8 = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ea = 8'($urandom); eb = 8'($urandom);
      a8 = ea; b8 = eb;
      cyc();
      vectors++;
      if ({and8, nand8, xor8, ov8} !== {ea & eb, ~(ea & eb), ea ^ eb, 1'b1}) begin
        miscompares++;
        $display("FAIL stream%0d got %h %h %h %b want %h %h %h 1", i, and8, nand8, xor8, ov8, ea & eb, ~(ea & eb), ea ^ eb);
      end
    end
    rst = 1'b1; a8 = 8'h0F; b8 = 8'h0F;
    cyc();
    vectors++;
    if ({and8, nand8, xor8, ov8} !== {8'h00, 8'hFF, 8'h00, 1'b0}) begin
      miscompares++;
      $display("FAIL rst_prio got %h %h %h %b want 00 ff 00 0", and8, nand8, xor8, ov8);
    end
    rst = 1'b0;
    cyc();
    vectors++;
    if ({and8, nand8, xor8, ov8} !== {8'h0F, 8'hF0, 8'h00, 1'b1}) begin
      miscompares++;
      $display("FAIL post_rst got %h %h %h %b want 0f f0 00 1", and8, nand8, xor8, ov8);
    end
    v8 = 1'b0;
  endtask
  task automatic test_random();
    logic [7:0] ha8, hb8;
    logic       ha1, hb1, hv1, hv8, r;
    ha8 = 8'h00; hb8 = 8'h00; ha1 = 1'b0; hb1 = 1'b0; hv1 = 1'b0; hv8 = 1'b0;
    rst = 1'b1;
    cyc();
    for (int i = 0; i < 1000; i++) begin
      r = ($urandom_range(99) == 0);
      rst = r;
      v1 = 1'($urandom); a1 = 1'($urandom); b1 = 1'($urandom);
      v8 = 1'($urandom); a8 = 8'($urandom); b8 = 8'($urandom);
      if (r) begin
        ha1 = 1'b0; hb1 = 1'b0; hv1 = 1'b0;
        ha8 = 8'h00; hb8 = 8'h00; hv8 = 1'b0;
      end else begin
        if (v1) begin ha1 = a1; hb1 = b1; end
        if (v8) begin ha8 = a8; hb8 = b8; end
        hv1 = v1; hv8 = v8;
      end
      cyc();
      vectors++;
      if ({and1, nand1, xor1, ov1} !== {ha1 & hb1, ~(ha1 & hb1), ha1 ^ hb1, hv1}) begin
        miscompares++;
        $display("FAIL rand_w1 i=%0d got %b%b%b%b want %b%b%b%b", i, and1, nand1, xor1, ov1, ha1 & hb1, ~(ha1 & hb1), ha1 ^ hb1, hv1);
      end
      vectors++;
      if ({and8, nand8, xor8, ov8} !== {ha8 & hb8, ~(ha8 & hb8), ha8 ^ hb8, hv8}) begin
        miscompares++;
        $display("FAIL rand_w8 i=%0d got %h %h %h %b want %h %h %h %b", i, and8, nand8, xor8, ov8, ha8 & hb8, ~(ha8 & hb8), ha8 ^ hb8, hv8);
      end
      vectors++;
      if (nand8 !== ~and8 || nand1 !== ~and1) begin
        miscompares++;
        $display("FAIL nand_inv i=%0d got nand8=%h and8=%h nand1=%b and1=%b want complements", i, nand8, and8, nand1, and1);
      end
    end
    rst = 1'b0; v1 = 1'b0; v8 = 1'b0;
  endtask
  initial begin
    test_reset();
    test_truth_table();
    test_hold();
    test_vector();
    test_reset_priority();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
